// File: rtl/paso8bto32b_pkg.sv
// Shared constants and types for the 8b->32b lane arbiter.
// Imported by the arbiter top and its round-robin selector.
package paso8bto32b_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W = 2;
  localparam int N_LANES = 1 << LANE_W;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [LANE_W-1:0] LAST_RST = LANE_W'(N_LANES - 1);

endpackage

// File: rtl/rr_selector.sv
// Combinational round-robin picker: first request after last.
// Produces one-hot grant and encoded lane index.
module rr_selector
  import paso8bto32b_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [LANE_W-1:0]  last,
  output logic [N_LANES-1:0] gnt,
  output logic [LANE_W-1:0]  idx
);

  logic [LANE_W-1:0] cand;
  logic              found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_LANES; i++) begin
      cand = last + LANE_W'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_paso8bto32b.sv
// Word-granular round-robin arbiter for four byte lanes feeding
// the shared 8b->32b converter; one lane owns four accepted bytes.
module arbitro_paso8bto32b
  import paso8bto32b_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int BYTES_PER_WORD = paso8bto32b_pkg::BYTES_PER_WORD
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in_0,
  input  logic [7:0]  data_in_1,
  input  logic [7:0]  data_in_2,
  input  logic [7:0]  data_in_3,
  input  logic        valid_0,
  input  logic        valid_1,
  input  logic        valid_2,
  input  logic        valid_3,
  output logic        ack_0,
  output logic        ack_1,
  output logic        ack_2,
  output logic        ack_3,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic [1:0]  lane_out,
  output logic        sow,
  output logic        eow,
  output logic [3:0]  grant
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t     state;
  logic [1:0] byte_cnt;
  logic [1:0] last;
  logic [3:0] req;
  logic [3:0] sel_gnt;
  logic [1:0] sel_idx;
  logic [3:0] ack;
  logic [1:0] acc_idx;
  logic       accepted;
  logic [7:0] din [NUM_LANES];

  assign req    = {valid_3, valid_2, valid_1, valid_0};
  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign din[3] = data_in_3;

  rr_selector u_sel (
    .req  (req),
    .last (last),
    .gnt  (sel_gnt),
    .idx  (sel_idx)
  );

  // While busy, last already names the owner of the word.
  always_comb begin
    ack     = '0;
    acc_idx = last;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          ack     = sel_gnt;
          acc_idx = sel_idx;
        end
        BUSY: ack = grant & req;
      endcase
    end
  end

  assign accepted = |ack;
  assign {ack_3, ack_2, ack_1, ack_0} = ack;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      last      <= LAST_RST;
      grant     <= '0;
      data_out  <= '0;
      lane_out  <= '0;
      valid_out <= 1'b0;
      sow       <= 1'b0;
      eow       <= 1'b0;
    end else begin
      valid_out <= accepted;
      sow       <= accepted && (byte_cnt == '0);
      eow       <= accepted && (byte_cnt == LAST_BYTE);
      if (accepted) begin
        data_out <= din[acc_idx];
        lane_out <= acc_idx;
      end
      unique case (state)
        IDLE: begin
          if (accepted) begin
            state    <= BUSY;
            grant    <= sel_gnt;
            last     <= sel_idx;
            byte_cnt <= 2'd1;
          end
        end
        BUSY: begin
          if (accepted) begin
            if (byte_cnt == LAST_BYTE) begin
              state    <= IDLE;
              grant    <= '0;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_paso8bto32b.sv
// Scoreboard bench for the lane arbiter: a word-level lane model
// predicts acks and output bytes; a negedge monitor checks them.
module tb_arbitro_paso8bto32b;

  typedef struct {
    logic [7:0] d;
    logic [1:0] l;
    logic       s;
    logic       e;
  } exp_t;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic [1:0] l;
  } obs_t;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] din [4];
  logic [3:0] vin;
  logic       ack_0, ack_1, ack_2, ack_3;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       sow, eow;
  logic [3:0] grant;
  logic [3:0] ack;

  assign ack = {ack_3, ack_2, ack_1, ack_0};

  arbitro_paso8bto32b dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in_0 (din[0]),
    .data_in_1 (din[1]),
    .data_in_2 (din[2]),
    .data_in_3 (din[3]),
    .valid_0   (vin[0]),
    .valid_1   (vin[1]),
    .valid_2   (vin[2]),
    .valid_3   (vin[3]),
    .ack_0     (ack_0),
    .ack_1     (ack_1),
    .ack_2     (ack_2),
    .ack_3     (ack_3),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .sow       (sow),
    .eow       (eow),
    .grant     (grant)
  );

  always #5 clk_4f = ~clk_4f;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t       exp_q [$];
  obs_t       obs_q [$];
  logic [7:0] src [4][$];
  logic [3:0] gseq [$];

  // Word-level model: owner of current word, position in word, last owner.
  int owner = -1;
  int pos   = 0;
  int lastl = 3;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_4f) begin : monitor
    exp_t e;
    cyc++;
    if (valid_out === 1'b1) begin
      obs_q.push_back('{cyc, data_out, lane_out});
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(data_out), 32'(e.d));
        check("out_lane", 32'(lane_out), 32'(e.l));
        check("out_sow", 32'(sow), 32'(e.s));
        check("out_eow", 32'(eow), 32'(e.e));
      end
    end else if (reset === 1'b0) begin
      check("idle_flags", 32'({sow, eow}), 32'd0);
    end
  end

  task automatic load(input int l, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    src[l].push_back(b0);
    src[l].push_back(b1);
    src[l].push_back(b2);
    src[l].push_back(b3);
  endtask

  task automatic cycle(input logic [3:0] want);
    int         acc;
    logic [3:0] eack;
    logic [3:0] egnt;
    for (int i = 0; i < 4; i++) begin
      vin[i] = want[i] && (src[i].size() > 0);
      din[i] = (src[i].size() > 0) ? src[i][0] : 8'($urandom);
    end
    #1;
    egnt = (owner < 0) ? 4'd0 : 4'(1 << owner);
    check("grant", 32'(grant), 32'(egnt));
    acc = -1;
    if (owner < 0) begin
      for (int k = 1; k <= 4; k++)
        if (acc < 0 && vin[(lastl + k) % 4]) acc = (lastl + k) % 4;
    end else if (vin[owner]) begin
      acc = owner;
    end
    eack = (acc < 0) ? 4'd0 : 4'(1 << acc);
    check("ack", 32'(ack), 32'(eack));
    if (grant != 4'd0 && (gseq.size() == 0 || gseq[$] != grant))
      gseq.push_back(grant);
    if (acc >= 0) begin
      exp_q.push_back('{src[acc][0], 2'(acc), pos == 0, pos == 3});
      void'(src[acc].pop_front());
      if (owner < 0) begin
        owner = acc;
        lastl = acc;
      end
      pos++;
      if (pos == 4) begin
        pos   = 0;
        owner = -1;
      end
    end
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    vin   = '0;
    reset = 1'b1;
    @(posedge clk_4f);
    #1;
    reset = 1'b0;
    owner = -1;
    pos   = 0;
    lastl = 3;
    for (int i = 0; i < 4; i++) src[i].delete();
  endtask

  task automatic check_obs(input string name, input int idx,
                           input logic [7:0] d, input logic [1:0] l);
    if (idx >= obs_q.size())
      check({name, "_missing"}, 32'(obs_q.size()), 32'(idx + 1));
    else
      check(name, {22'd0, obs_q[idx].l, obs_q[idx].d}, {22'd0, l, d});
  endtask

  task automatic check_gap(input string name, input int i, input int j,
                           input int g);
    if (j >= obs_q.size())
      check({name, "_missing"}, 32'(obs_q.size()), 32'(j + 1));
    else
      check(name, 32'(obs_q[j].c - obs_q[i].c), 32'(g));
  endtask

  initial begin
    reset = 1'b1;
    vin   = '0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    repeat (2) @(posedge clk_4f);
    #1;
    reset = 1'b0;
    check("reset_outs", {13'd0, valid_out, data_out, lane_out, sow, eow, grant},
          32'd0);
    check("reset_acks", 32'(ack), 32'd0);

    // Single lane word
    obs_q.delete();
    load(0, 8'h1F, 8'h2F, 8'h3F, 8'h4F);
    repeat (4) cycle(4'b0001);
    repeat (2) cycle(4'b0000);
    check("single_cnt", 32'(obs_q.size()), 32'd4);
    check_obs("single_b0", 0, 8'h1F, 2'd0);
    check_obs("single_b1", 1, 8'h2F, 2'd0);
    check_obs("single_b2", 2, 8'h3F, 2'd0);
    check_obs("single_b3", 3, 8'h4F, 2'd0);
    check_gap("single_contig", 0, 3, 3);

    // All lanes valid together
    do_reset();
    obs_q.delete();
    gseq.delete();
    for (int i = 0; i < 4; i++)
      load(i, 8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3), 8'(i * 16 + 4));
    repeat (18) cycle(4'b1111);
    check("all_cnt", 32'(obs_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      check_obs("all_byte", i, 8'((i / 4) * 16 + (i % 4) + 1), 2'(i / 4));
    check_gap("all_contig", 0, 15, 15);
    check("all_gseq_n", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < gseq.size() && i < 4; i++)
      check("all_gseq", 32'(gseq[i]), 32'(1 << i));

    // Mid-word stall on lane 2 with lane 1 waiting
    do_reset();
    obs_q.delete();
    load(2, 8'h1D, 8'h2D, 8'h3D, 8'h4D);
    load(1, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    cycle(4'b0100);
    cycle(4'b0110);
    repeat (3) cycle(4'b0010);
    repeat (2) cycle(4'b0110);
    repeat (4) cycle(4'b0010);
    repeat (2) cycle(4'b0000);
    check_obs("stall_b0", 0, 8'h1D, 2'd2);
    check_obs("stall_b1", 1, 8'h2D, 2'd2);
    check_obs("stall_b2", 2, 8'h3D, 2'd2);
    check_obs("stall_b3", 3, 8'h4D, 2'd2);
    check_obs("stall_l1", 4, 8'hA1, 2'd1);
    check_obs("stall_l1e", 7, 8'hA4, 2'd1);
    check_gap("stall_gap", 1, 2, 4);
    check_gap("stall_next", 3, 4, 1);

    // Fairness rotation: 3 -> 0 -> 3
    do_reset();
    obs_q.delete();
    load(3, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    load(3, 8'hC5, 8'hC6, 8'hC7, 8'hC8);
    load(0, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
    cycle(4'b1000);
    repeat (11) cycle(4'b1001);
    repeat (2) cycle(4'b0000);
    check_obs("fair_w0", 0, 8'hC1, 2'd3);
    check_obs("fair_w1", 4, 8'hB1, 2'd0);
    check_obs("fair_w2", 8, 8'hC5, 2'd3);
    check_gap("fair_contig", 0, 11, 11);

    // Reset mid-word
    do_reset();
    obs_q.delete();
    load(1, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) cycle(4'b0010);
    do_reset();
    check("rst_outs", {13'd0, valid_out, data_out, lane_out, sow, eow, grant},
          32'd0);
    check("rst_partial", 32'(obs_q.size()), 32'd2);
    obs_q.delete();
    load(1, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
    load(0, 8'hF1, 8'hF2, 8'hF3, 8'hF4);
    repeat (8) cycle(4'b0011);
    repeat (2) cycle(4'b0000);
    check_obs("rst_first", 0, 8'hF1, 2'd0);
    check_obs("rst_second", 4, 8'hE1, 2'd1);

    // Idle after a word: data_out holds
    do_reset();
    load(2, 8'h00, 8'h01, 8'h02, 8'h03);
    repeat (4) cycle(4'b0100);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000);
      check("idle_flags_all", 32'({valid_out, sow, eow, grant}), 32'd0);
      check("idle_hold", 32'(data_out), 32'h03);
    end

    // Randomized traffic with occasional reset
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++)
        while (src[i].size() < 3) src[i].push_back(8'($urandom));
      if (n % 200 == 199) do_reset();
      else cycle(4'($urandom));
    end
    repeat (3) cycle(4'b0000);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
